// File: rtl/bcd_cascade_display_if.sv
// Bundle between the decade-counter consumer and its environment.
//   units    : BCD units digit from the upstream decade counter
//   ten_in   : carry pulse from the decade counter
//   clear    : synchronous clear of the upper digits and overflow
//   hold     : freeze the displayed snapshot
//   digits   : registered {thousands,hundreds,tens,units} snapshot
//   overflow : sticky 9999->0000 wrap flag
//   an       : active-low anode enables, one-hot-low
//   seg      : active-low segments {g,f,e,d,c,b,a}
interface bcd_cascade_display_if;
   logic [3:0]  units;
   logic        ten_in;
   logic        clear;
   logic        hold;
   logic [15:0] digits;
   logic        overflow;
   logic [3:0]  an;
   logic [6:0]  seg;

   modport master (
      output units, ten_in, clear, hold,
      input  digits, overflow, an, seg
   );

   modport slave (
      input  units, ten_in, clear, hold,
      output digits, overflow, an, seg
   );
endinterface

// File: rtl/bcd_cascade_display.sv
// Extends an upstream decade counter to four BCD digits and drives a
// 4-digit common-anode seven-segment display with multiplexed scan.
//   i_clk   : system clock, all state on the rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : bcd_cascade_display_if slave (units/ten_in/clear/hold in,
//             digits/overflow/an/seg out)
module bcd_cascade_display #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   bcd_cascade_display_if.slave   bus
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

   logic            r_ten_q;
   logic [3:0]      r_tens;
   logic [3:0]      r_hund;
   logic [3:0]      r_thou;
   logic            r_overflow;
   logic [15:0]     r_digits;
   logic [CntW-1:0] r_refresh;
   logic [1:0]      r_idx;
   logic [3:0]      r_an;
   logic [6:0]      r_seg;

   logic            w_inc;
   logic [3:0]      w_tens_d;
   logic [3:0]      w_hund_d;
   logic [3:0]      w_thou_d;
   logic            w_ovf_d;
   logic [1:0]      w_idx_nxt;
   logic [3:0]      w_sel;
   logic            w_blank;
   logic [6:0]      w_seg_nxt;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111; // dash for non-BCD units
      endcase
      return s;
   endfunction

   // Rising edge of the carry: a held level counts once.
   assign w_inc = bus.ten_in & ~r_ten_q;

   // BCD ripple; clear wins over a coincident increment.
   always_comb begin
      w_tens_d = r_tens;
      w_hund_d = r_hund;
      w_thou_d = r_thou;
      w_ovf_d  = r_overflow;
      if (bus.clear) begin
         w_tens_d = 4'd0;
         w_hund_d = 4'd0;
         w_thou_d = 4'd0;
         w_ovf_d  = 1'b0;
      end else if (w_inc) begin
         if (r_tens == 4'd9) begin
            w_tens_d = 4'd0;
            if (r_hund == 4'd9) begin
               w_hund_d = 4'd0;
               if (r_thou == 4'd9) begin
                  w_thou_d = 4'd0;
                  w_ovf_d  = 1'b1;
               end else begin
                  w_thou_d = r_thou + 4'd1;
               end
            end else begin
               w_hund_d = r_hund + 4'd1;
            end
         end else begin
            w_tens_d = r_tens + 4'd1;
         end
      end
   end

   // Segment pattern for the digit the scan moves to next; always taken
   // from the registered snapshot so hold freezes the display too.
   always_comb begin
      w_idx_nxt = r_idx + 2'd1;
      w_sel     = 4'd0;
      w_blank   = 1'b0;
      case (w_idx_nxt)
         2'd0: begin
            w_sel   = r_digits[3:0];
            w_blank = 1'b0;
         end
         2'd1: begin
            w_sel   = r_digits[7:4];
            w_blank = BLANK_LZ && (r_digits[15:4] == 12'd0);
         end
         2'd2: begin
            w_sel   = r_digits[11:8];
            w_blank = BLANK_LZ && (r_digits[15:8] == 8'd0);
         end
         default: begin
            w_sel   = r_digits[15:12];
            w_blank = BLANK_LZ && (r_digits[15:12] == 4'd0);
         end
      endcase
      w_seg_nxt = w_blank ? 7'b1111111 : f_decode(w_sel);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ten_q    <= 1'b0;
         r_tens     <= 4'd0;
         r_hund     <= 4'd0;
         r_thou     <= 4'd0;
         r_overflow <= 1'b0;
         r_digits   <= 16'h0000;
         r_refresh  <= '0;
         r_idx      <= 2'd0;
         r_an       <= 4'b1111;
         r_seg      <= 7'b1111111;
      end else begin
         r_ten_q    <= bus.ten_in;
         r_tens     <= w_tens_d;
         r_hund     <= w_hund_d;
         r_thou     <= w_thou_d;
         r_overflow <= w_ovf_d;
         if (!bus.hold) begin
            r_digits <= {r_thou, r_hund, r_tens, bus.units};
         end
         if (r_refresh == CntLast) begin
            r_refresh <= '0;
            r_idx     <= w_idx_nxt;
            r_an      <= ~(4'b0001 << w_idx_nxt);
            r_seg     <= w_seg_nxt;
         end else begin
            r_refresh <= r_refresh + CntW'(1);
         end
      end
   end

   assign bus.digits   = r_digits;
   assign bus.overflow = r_overflow;
   assign bus.an       = r_an;
   assign bus.seg      = r_seg;

endmodule

// File: doc/bcd_cascade_display.md
Name: bcd_cascade_display

Overview:
- Downstream consumer of the single-digit decade counter stage.
- Takes the counter's BCD units digit and its one-cycle carry pulse, and extends the count to four BCD digits (0000–9999) by cascading internal tens, hundreds and thousands digits.
- Drives a 4-digit common-anode seven-segment display: time-multiplexed scan, leading-zero blanking, display hold, sticky overflow flag.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit during scan; legal range ≥2.
- BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- units  input  4  BCD units digit from the decade counter.
- ten_in  input  1  carry pulse from the decade counter; high for one clk when units wraps 9->0.
- clear  input  1  synchronous clear of the upper digits and overflow.
- hold  input  1  1 = freeze displayed value and digits output; counting continues.
- digits  output  16  {thousands,hundreds,tens,units} BCD snapshot, registered.
- overflow  output  1  sticky; set when the count wraps 9999->0000.
- an  output  4  anode enables, active-low, one-hot-low.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst=0, asynchronous, immediate, also mid-scan or mid-carry):
  - tens/hundreds/thousands=0, digits=16'h0000, overflow=0.
  - scan index=0, refresh counter=0, ten_q=0.
  - an=4'b1111, seg=7'b1111111.
- Carry detect:
  - ten_q registers ten_in every cycle.
  - inc = ten_in & ~ten_q, i.e. a rising edge. A level held high for N cycles counts once.
- Cascade on inc:
  - tens+1. If tens==9: tens=0, hundreds+1.
  - Same rule hundreds->thousands.
  - If thousands==9 also wraps, all three become 0 and overflow<=1.
  - Update visible on the next cycle (1-cycle latency from ten_in rising).
- clear=1:
  - Next edge: upper digits=0, overflow=0.
  - Overrides a coincident inc; that inc is dropped.
  - ten_q still updates.
  - clear does not touch the scan or units (units belongs to upstream).
- Snapshot:
  - When hold=0, digits <= {thousands,hundreds,tens,units} every cycle.
  - When hold=1, digits is retained. Internal counting and overflow continue.
  - Releasing hold reloads digits on the next edge.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - On the terminal count, index <= (index+1) mod 4; an/seg are registered for the new index in the same edge.
  - an = ~(4'b0001 << index); index 0 = units (rightmost).
  - Display source is always digits, never the live counters.
  - First lit digit after reset appears REFRESH_DIV cycles after rst release, showing index 1.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Illegal units value (A–F) shows dash 0111111. Upper digits can never be illegal.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k=3..1) shows 1111111 if it and all higher digits are 0.
  - Units digit is never blanked; it shows 0.
  - BLANK_LZ=0: no blanking.
- Simultaneous events:
  - rst dominates all.
  - clear dominates inc.
  - hold is independent of clear/inc: a clear during hold zeroes the counters but not the displayed value until hold drops.
- Width rule: all digit arithmetic is 4-bit BCD; no binary intermediate.

Test Plan (REFRESH_DIV=4 for simulation):
1. Reset, then drive 23 ten_in pulses with units=4 -> digits=16'h0234, overflow=0. Scanned an/seg sequence over 16 cycles: index1 seg=0110000 (3), index2 seg=0100100 (2), index3 blank 1111111, index0 seg=0011001 (4).
2. Preload to 999x via 999 pulses, then one more pulse -> digits upper=000, overflow=1. overflow stays 1 through 5 further pulses; clear -> overflow=0, upper digits=0.
3. Hold ten_in high 10 cycles -> tens increments exactly once. Pulses 1-0-1 on consecutive cycles -> increments twice.
4. hold=1 with digits=16'h0056, then 30 pulses -> digits and displayed seg stay 0056. hold=0 -> next cycle digits=16'h0356.
5. clear and ten_in rising in the same cycle -> upper digits=0, no increment. units=4'hC -> index0 seg=0111111.
6. Assert rst mid-scan at index 2 and mid-count 0478 -> an=1111, seg=1111111, digits=0000 immediately (before next clk edge). Release -> scan resumes from index 0 counter 0.
